// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if -- fetch-control bundle between the core datapath and ifetch_ctrl.
//
// Signals:
//   ecall            decoder flag: current instruction is ecall
//   continue_button  raw asynchronous board button, active-high
//   step_mode        1 = stop after every executed instruction
//   stall            1 = hold pc this cycle
//   next_pc          target from the next-PC mux
//   pc               current fetch address
//   pc_valid         0 during the boot cycle, 1 afterwards
//   halted           1 while the fetch unit is halted
//   retire_count     pc advances since reset, wraps silently
//
// Modports:
//   master  core / environment side (drives the controls, consumes pc)
//   slave   ifetch_ctrl side
interface ifetch_ctrl_if #(
  parameter int PC_WIDTH    = 32,
  parameter int COUNT_WIDTH = 32
);
  logic                   ecall;
  logic                   continue_button;
  logic                   step_mode;
  logic                   stall;
  logic [PC_WIDTH-1:0]    next_pc;
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_valid;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] retire_count;

  modport master (
    output ecall, continue_button, step_mode, stall, next_pc,
    input  pc, pc_valid, halted, retire_count
  );

  modport slave (
    input  ecall, continue_button, step_mode, stall, next_pc,
    output pc, pc_valid, halted, retire_count
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl -- program counter and fetch control for the single-cycle core.
//
// Holds the PC, inserts one boot cycle after reset, halts on ecall or after a
// single step, and resumes on a synchronised, debounced press-and-release of
// the continue button. Counts every pc advance in retire_count.
// All state changes on the falling edge of clock.
//
// Ports:
//   clock  core clock (falling-edge active)
//   reset  asynchronous, active-low reset
//   bus    ifetch_ctrl_if.slave: ecall, continue_button, step_mode, stall,
//          next_pc in; pc, pc_valid, halted, retire_count out
module ifetch_ctrl #(
  parameter int                  PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter int                  COUNT_WIDTH     = 32
) (
  input  logic         clock,
  input  logic         reset,
  ifetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchroniser: continue_button enters at bit 0, leaves at the top.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   continue_pulse;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.continue_button};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce and release detection. The pulse fires on a debounced 1->0
  // transition so a resume needs a full press-and-release.
  // ---------------------------------------------------------------------------
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      logic level_d_reg;

      always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
          level_d_reg <= 1'b0;
        end else begin
          level_d_reg <= sync_out;
        end
      end

      // Combinational edge detect keeps the bypass latency at SYNC_STAGES + 1.
      assign continue_pulse = level_d_reg & ~sync_out;
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             pulse_reg;

      always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          if (sync_out == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            // This would be the DEBOUNCE_CYCLES-th differing cycle: flip.
            cnt_reg   <= '0;
            level_reg <= sync_out;
            pulse_reg <= level_reg;  // only a 1->0 flip produces a pulse
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign continue_pulse = pulse_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_t                 state_reg;
  logic                   pending_reg;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic                   pc_valid_reg;
  logic                   halted_reg;
  logic [COUNT_WIDTH-1:0] retire_count_reg;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_BOOT;
      pending_reg      <= 1'b0;
      pc_reg           <= RESET_PC;
      pc_valid_reg     <= 1'b0;
      halted_reg       <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_BOOT: begin
          state_reg    <= ST_RUN;
          pc_valid_reg <= 1'b1;
        end

        ST_RUN: begin
          // Pulses seen while running are discarded.
          pending_reg <= 1'b0;
          if (!bus.stall) begin
            if (bus.ecall) begin
              // Stay on the ecall instruction.
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
            end else begin
              pc_reg           <= bus.next_pc;
              retire_count_reg <= retire_count_reg + COUNT_WIDTH'(1);
              if (bus.step_mode) begin
                state_reg  <= ST_HALT;
                halted_reg <= 1'b1;
              end
            end
          end
        end

        ST_HALT: begin
          if ((pending_reg || continue_pulse) && !bus.stall) begin
            pc_reg           <= bus.next_pc;
            retire_count_reg <= retire_count_reg + COUNT_WIDTH'(1);
            pending_reg      <= 1'b0;
            if (!bus.step_mode) begin
              state_reg  <= ST_RUN;
              halted_reg <= 1'b0;
            end
          end else if (continue_pulse) begin
            // Remember the request; further pulses collapse into this one.
            pending_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= ST_BOOT;
          pending_reg  <= 1'b0;
          pc_valid_reg <= 1'b0;
          halted_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_reg;
  assign bus.pc_valid     = pc_valid_reg;
  assign bus.halted       = halted_reg;
  assign bus.retire_count = retire_count_reg;

endmodule
